// File: rtl/prio_arbiter8_if.sv
`default_nettype none
// ============================================================================
// Module      : prio_arbiter8_if
// Description : Request/grant bundle between eight clients and prio_arbiter8.
//               req/mode come from the client side; gnt, gnt_idx, gnt_valid
//               and preempt are returned by the arbiter.
//                 req       [7:0] bit k high = client k wants/uses resource
//                 mode            0 = fixed priority, 1 = round-robin
//                 gnt       [7:0] registered one-hot grant
//                 gnt_idx   [2:0] index of granted client (0 when idle)
//                 gnt_valid       a grant is active
//                 preempt         one-cycle pulse after a hold-limit release
// Revision    : 1.0 - initial release
// ============================================================================
interface prio_arbiter8_if;
    logic [7:0] req;
    logic       mode;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    // Client side drives requests and mode, observes the grant.
    modport master (
        output req,
        output mode,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  preempt
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  mode,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output preempt
    );
endinterface
`default_nettype wire

// File: rtl/prio_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : prio_arbiter8
// Description : Eight-requester arbiter, fixed priority or round-robin.
//               The winner is the first set request scanning down from a
//               search pointer (7 in fixed mode, stored ptr in round-robin).
//               A grant is held while the winner keeps requesting, up to
//               MAX_HOLD cycles, then forcibly released with a preempt pulse.
//               Every release is followed by one idle bubble cycle.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset
//               bus        - prio_arbiter8_if.slave (req, mode in;
//                            gnt, gnt_idx, gnt_valid, preempt out)
// Parameters  : MAX_HOLD   - max consecutive grant cycles (2..255)
// Revision    : 1.0 - initial release
// ============================================================================
module prio_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    prio_arbiter8_if.slave     bus
);

    localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     r_state,     w_state_nxt;
    logic [2:0] r_ptr,       w_ptr_nxt;
    logic [7:0] r_hold_cnt,  w_hold_cnt_nxt;
    logic       r_rr_mode,   w_rr_mode_nxt;   // mode latched at arbitration
    logic [7:0] r_gnt,       w_gnt_nxt;
    logic [2:0] r_gnt_idx,   w_gnt_idx_nxt;
    logic       r_gnt_valid, w_gnt_valid_nxt;
    logic       r_preempt,   w_preempt_nxt;

    // ------------------------------------------------------------------
    // Winner search: scan ptr, ptr-1, ... ptr-7 (mod 8), first set wins.
    // ------------------------------------------------------------------
    logic [2:0] w_search_ptr;
    logic [2:0] w_cand;
    logic [2:0] w_winner;
    logic       w_found;

    always_comb begin
        w_search_ptr = bus.mode ? r_ptr : 3'd7;
        w_cand       = 3'd0;
        w_winner     = 3'd0;
        w_found      = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w_cand = w_search_ptr - 3'(i);
            if (!w_found && bus.req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    logic w_owner_req;
    logic w_limit;

    assign w_owner_req = bus.req[r_gnt_idx];
    assign w_limit     = (r_hold_cnt == c_max_hold);

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_rr_mode_nxt   = r_rr_mode;
        w_gnt_nxt       = r_gnt;
        w_gnt_idx_nxt   = r_gnt_idx;
        w_gnt_valid_nxt = r_gnt_valid;
        w_preempt_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt     = ST_GRANT;
                    w_gnt_nxt       = 8'd1 << w_winner;
                    w_gnt_idx_nxt   = w_winner;
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_cnt_nxt  = 8'd1;
                    w_rr_mode_nxt   = bus.mode;
                end
            end
            ST_GRANT: begin
                if (!w_owner_req || w_limit) begin
                    // Release: a still-requesting owner means a forced release.
                    w_state_nxt     = ST_IDLE;
                    w_gnt_nxt       = 8'd0;
                    w_gnt_idx_nxt   = 3'd0;
                    w_gnt_valid_nxt = 1'b0;
                    w_hold_cnt_nxt  = 8'd0;
                    w_preempt_nxt   = w_owner_req;
                    // Round-robin: the released client becomes last in order.
                    if (r_rr_mode) begin
                        w_ptr_nxt = r_gnt_idx - 3'd1;
                    end
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 3'd7;
            r_hold_cnt  <= 8'd0;
            r_rr_mode   <= 1'b0;
            r_gnt       <= 8'd0;
            r_gnt_idx   <= 3'd0;
            r_gnt_valid <= 1'b0;
            r_preempt   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_rr_mode   <= w_rr_mode_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_preempt   <= w_preempt_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_idx   = r_gnt_idx;
    assign bus.gnt_valid = r_gnt_valid;
    assign bus.preempt   = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_prio_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : tb_prio_arbiter8
// Description : Self-checking bench for prio_arbiter8 (MAX_HOLD = 4).
//               Directed scenarios followed by random requests, each cycle
//               compared against a tenure-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prio_arbiter8;

    localparam int c_max_hold = 4;

    logic clk;
    logic rst;

    prio_arbiter8_if bus ();

    prio_arbiter8 #(.MAX_HOLD(c_max_hold)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp;
    int n_fail;

    // Reference model: who owns the resource, for how long, and the
    // round-robin pointer.
    bit       m_busy;
    int       m_owner;
    int       m_tenure;
    int       m_ptr;
    bit       m_rr;
    bit       m_preempt;

    // First requester found walking down from p, wrapping around.
    function automatic int pick(logic [7:0] r, int p);
        for (int k = 0; k < 8; k++) begin
            int c;
            c = (p - k + 8) % 8;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_edge(logic r_s, logic [7:0] q, logic md);
        if (r_s) begin
            m_busy = 0; m_owner = 0; m_tenure = 0; m_ptr = 7; m_preempt = 0; m_rr = 0;
        end else if (!m_busy) begin
            m_preempt = 0;
            if (q != 8'd0) begin
                m_owner  = pick(q, md ? m_ptr : 7);
                m_busy   = 1;
                m_tenure = 1;
                m_rr     = md;
            end
        end else begin
            bit forced;
            forced = q[m_owner] && (m_tenure == c_max_hold);
            if (!q[m_owner] || forced) begin
                if (m_rr) m_ptr = (m_owner + 7) % 8;
                m_busy    = 0;
                m_owner   = 0;
                m_tenure  = 0;
                m_preempt = forced;
            end else begin
                m_tenure++;
                m_preempt = 0;
            end
        end
    endtask

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: model follows the inputs seen at the edge, then outputs
    // are compared 1 time unit later.
    task automatic step();
        logic [7:0] exp_gnt;
        @(posedge clk);
        model_edge(rst, bus.req, bus.mode);
        #1;
        exp_gnt = m_busy ? (8'd1 << m_owner) : 8'd0;
        chk("gnt",       bus.gnt,              exp_gnt);
        chk("gnt_idx",   {5'd0, bus.gnt_idx},  8'(m_owner));
        chk("gnt_valid", {7'd0, bus.gnt_valid}, {7'd0, m_busy});
        chk("preempt",   {7'd0, bus.preempt},   {7'd0, m_preempt});
    endtask

    initial begin
        int order [9];
        n_cmp  = 0;
        n_fail = 0;
        m_busy = 0; m_owner = 0; m_tenure = 0; m_ptr = 7; m_rr = 0; m_preempt = 0;

        // ---------------- Reset with all requests high ----------------
        rst = 1'b1; bus.req = 8'hFF; bus.mode = 1'b0;
        step();
        step();
        chk("rst_gnt",   bus.gnt, 8'h00);
        chk("rst_valid", {7'd0, bus.gnt_valid}, 8'd0);
        rst = 1'b0;
        step();
        chk("first_gnt", bus.gnt, 8'h80);
        chk("first_idx", {5'd0, bus.gnt_idx}, 8'd7);
        bus.req = 8'h00;
        step();
        step();

        // ---------------- Fixed priority, drop bit 5 ----------------
        bus.mode = 1'b0; bus.req = 8'b0010_0110;
        step(); chk("fix_idx5_a", {5'd0, bus.gnt_idx}, 8'd5);
        step(); chk("fix_idx5_b", {5'd0, bus.gnt_idx}, 8'd5);
        step(); chk("fix_idx5_c", {5'd0, bus.gnt_idx}, 8'd5);
        bus.req = 8'b0000_0110;
        step(); chk("fix_bubble", bus.gnt, 8'h00);
        step(); chk("fix_gnt2",   bus.gnt, 8'b0000_0100);
        bus.req = 8'h00;
        step();
        step();

        // ---------------- Round-robin rotation ----------------
        order = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        bus.mode = 1'b1; bus.req = 8'hFF;
        for (int t = 0; t < 9; t++) begin
            bus.req = 8'hFF;
            step(); chk("rr_win",  {5'd0, bus.gnt_idx}, 8'(order[t]));
            step(); chk("rr_hold", {5'd0, bus.gnt_idx}, 8'(order[t]));
            bus.req = 8'hFF & ~(8'd1 << order[t]);
            step(); chk("rr_bubble", {7'd0, bus.gnt_valid}, 8'd0);
        end
        bus.req = 8'h00;
        step();

        // ---------------- Hold limit / preemption ----------------
        bus.mode = 1'b1; bus.req = 8'b0000_1000;
        for (int c = 0; c < c_max_hold; c++) begin
            step(); chk("hl_idx3", {5'd0, bus.gnt_idx}, 8'd3);
        end
        step();
        chk("hl_preempt", {7'd0, bus.preempt}, 8'd1);
        chk("hl_gnt0",    bus.gnt, 8'h00);
        step(); chk("hl_regrant3", {5'd0, bus.gnt_idx}, 8'd3);
        step(); step(); step();
        bus.req = 8'b0001_1000;
        step(); chk("hl_preempt2", {7'd0, bus.preempt}, 8'd1);
        step(); chk("hl_next4", {5'd0, bus.gnt_idx}, 8'd4);
        bus.req = 8'h00;
        step();
        step();

        // ---------------- Reset mid-grant ----------------
        bus.mode = 1'b1; bus.req = 8'b0000_0100;
        step(); chk("mr_idx2", {5'd0, bus.gnt_idx}, 8'd2);
        step();
        rst = 1'b1; bus.req = 8'hFF;
        step(); chk("mr_gnt0", bus.gnt, 8'h00);
        rst = 1'b0;
        step(); chk("mr_idx7", {5'd0, bus.gnt_idx}, 8'd7);
        bus.req = 8'h00;
        step();
        step();

        // ---------------- Mode switch during tenure ----------------
        bus.mode = 1'b1; bus.req = 8'b1000_0011;
        step(); chk("ms_idx1", {5'd0, bus.gnt_idx}, 8'd1);
        bus.mode = 1'b0;
        step(); chk("ms_hold1", {5'd0, bus.gnt_idx}, 8'd1);
        bus.req = 8'b1000_0001;
        step(); chk("ms_bubble", bus.gnt, 8'h00);
        step(); chk("ms_idx7", {5'd0, bus.gnt_idx}, 8'd7);
        bus.req = 8'h00;
        step();
        step();

        // ---------------- Random traffic ----------------
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 8'($urandom);
            if ($urandom_range(0, 7) == 0) bus.mode = 1'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
